// File: rtl/contador_pkg.sv
// Shared definitions for the universal counter: direction encoding and the default width.
package contador_pkg;

   // Direction values carried on the 'up' input
   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } dir_e;

   localparam int DEF_WIDTH = 4;

endpackage : contador_pkg

// File: rtl/contador_next_state.sv
// Combinational next-count logic for the universal counter.
// Given the current count, the direction and the upper bound, it produces the
// following count and a flag marking a step past either end of the range.
// Optional feature macro: CONTADOR_SATURATE_EN (hold at the bound instead of wrapping).
module contador_next_state
   import contador_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_up,
   input  logic [WIDTH-1:0] i_max,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap
);

   // Step one position in the requested direction; flag the boundary crossing
   always_comb begin
      o_next = i_q;
      o_wrap = 1'b0;
      if (i_up == UP) begin
         if (i_q == i_max) begin
            o_wrap = 1'b1;
`ifdef CONTADOR_SATURATE_EN
            o_next = i_q;
`else
            o_next = '0;
`endif
         end else begin
            o_next = i_q + WIDTH'(1);
         end
      end else begin
         if (i_q == '0) begin
            o_wrap = 1'b1;
`ifdef CONTADOR_SATURATE_EN
            o_next = i_q;
`else
            o_next = i_max;
`endif
         end else begin
            o_next = i_q - WIDTH'(1);
         end
      end
   end

endmodule : contador_next_state

// File: rtl/contador_universal_nbits.sv
// Universal up/down modulo-N counter with parallel load, combinational
// terminal count and a sticky overflow flag.
// Optional feature macro: CONTADOR_SATURATE_EN (saturate at the range ends
// instead of wrapping; the overflow flag then marks the first blocked step).
module contador_universal_nbits
   import contador_pkg::*;
#(
   parameter int              WIDTH  = DEF_WIDTH,
   // 64-bit so that the default 2**WIDTH still fits when WIDTH is 32
   parameter longint unsigned MODULO = 64'd1 << WIDTH
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 64'd1);

   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   logic [WIDTH-1:0] w_next;
   logic             w_wrap;
   logic [WIDTH-1:0] w_load_val;
   logic             w_max_vec_unused;

   // Out-of-range load values are clamped so no state above MAX_Q is reachable
   assign w_load_val = (64'(d) >= MODULO) ? MAX_Q : d;
   assign w_max_vec_unused = 1'b0;

   contador_next_state #(
      .WIDTH (WIDTH)
   ) u_next (
      .i_q    (r_q),
      .i_up   (up),
      .i_max  (MAX_Q),
      .o_next (w_next),
      .o_wrap (w_wrap)
   );

   // Count register and sticky overflow: load beats count, count beats hold
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_q   <= '0;
         r_ovf <= 1'b0;
      end else if (load) begin
         r_q   <= w_load_val;
         r_ovf <= 1'b0;
      end else if (en) begin
         r_q <= w_next;
         if (w_wrap) r_ovf <= 1'b1;
      end
   end

   // Terminal count looks at the live inputs; during reset r_q is already 0
   assign tc  = en & ~load & ((up & (r_q == MAX_Q)) | (~up & (r_q == '0)));
   assign q   = r_q;
   assign ovf = r_ovf | w_max_vec_unused;

endmodule : contador_universal_nbits
